// File: rtl/adc_serial_reader.sv
// Purpose: scans NUM_CH ADC channels, handles calibration/sleep, deserialises DATA_W-bit samples MSB-first.
// Latency: data_valid pulses 2*DATA_W*CLK_DIV+1 cycles after cs_n falls (first SHIFT cycle).
// Backpressure: none; a sample is a one-cycle pulse; drdy_n high before the last sclk rise aborts the transfer.
module adc_serial_reader #(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 4,
  parameter int CLK_DIV = 4,
  parameter int CAL_LEN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cal_req,
  output logic [1:0]        SC,
  output logic              cal,
  output logic              sleep_n,
  output logic              cs_n,
  input  logic              drdy_n,
  output logic              sclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        data_ch,
  output logic              data_valid,
  output logic              abort_err
);

  typedef enum logic [2:0] {IDLE, CAL, WAIT, SHIFT, DONE} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0]  BITS     = 6'(DATA_W);
  localparam logic [15:0] CAL_LAST = 16'(CAL_LEN - 1);
  localparam logic [1:0]  CH_LAST  = 2'(NUM_CH - 1);

  state_t              state, state_nxt;
  logic                cal_pend;
  logic [7:0]          div_cnt;
  logic [5:0]          bit_cnt;
  logic [15:0]         cal_cnt;
  logic [DATA_W-1:0]   shreg;

  logic div_wrap, shift_abort, shift_end, cal_end;

  // Divider wrap marks an sclk toggle; a transfer ends on the falling toggle after the last rise,
  // and aborts if the ADC withdraws drdy_n before all DATA_W rises have been taken.
  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    shift_abort = (state == SHIFT) && drdy_n && (bit_cnt < BITS);
    shift_end   = (state == SHIFT) && div_wrap && sclk && (bit_cnt == BITS);
    cal_end     = (state == CAL) && (cal_cnt == CAL_LAST);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; CAL and SHIFT always run to completion before enable is honoured.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = cal_pend ? CAL : WAIT;
      CAL:     if (cal_end) state_nxt = WAIT;
      WAIT: begin
        if (!enable)       state_nxt = IDLE;
        else if (cal_pend) state_nxt = CAL;
        else if (!drdy_n)  state_nxt = SHIFT;
      end
      SHIFT: begin
        if (shift_abort)    state_nxt = WAIT;
        else if (shift_end) state_nxt = DONE;
      end
      DONE:    state_nxt = enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ADC control strobes decoded straight from the state.
  always_comb begin
    sleep_n = (state != IDLE);
    cs_n    = (state != SHIFT);
    cal     = (state == CAL);
  end

  // Datapath: cal request latch, cal timer, sclk divider, shifter, sample/channel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cal_pend   <= 1'b0;
      cal_cnt    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      shreg      <= '0;
      SC         <= '0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      abort_err  <= 1'b0;
    end else begin
      // Entering CAL consumes the request; requests arriving while pending merge into it.
      if (state != CAL && state_nxt == CAL) cal_pend <= 1'b0;
      else if (cal_req)                     cal_pend <= 1'b1;

      cal_cnt <= (state == CAL && !cal_end) ? cal_cnt + 16'd1 : 16'd0;

      if (state == SHIFT && !shift_abort) begin
        if (div_wrap) begin
          div_cnt <= '0;
          sclk    <= ~sclk;
          if (!sclk) begin
            shreg   <= {shreg[DATA_W-2:0], sdata};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
      end

      if (shift_abort) begin
        shreg     <= '0;
        abort_err <= 1'b1;
      end

      data_valid <= (state == DONE);
      if (state == DONE) begin
        data    <= shreg;
        data_ch <= SC;
        SC      <= (SC == CH_LAST) ? 2'd0 : SC + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Purpose: randomized scoreboard bench for adc_serial_reader (DATA_W=16, NUM_CH=3, CLK_DIV=2, CAL_LEN=8).
// Latency: expected samples carry their due cycle (cs_n fall + 2*DATA_W*CLK_DIV + 1).
// Backpressure: not applicable; the monitor pops one expectation per data_valid pulse.
module tb_adc_serial_reader;

  localparam int DW  = 16;
  localparam int NCH = 3;
  localparam int CD  = 2;
  localparam int CL  = 8;
  localparam int LAT = 2 * DW * CD + 1;

  logic          clock = 1'b0;
  logic          reset, enable, cal_req, drdy_n, sdata;
  logic [1:0]    SC, data_ch;
  logic          cal, sleep_n, cs_n, sclk, data_valid, abort_err;
  logic [DW-1:0] data;

  adc_serial_reader #(.DATA_W(DW), .NUM_CH(NCH), .CLK_DIV(CD), .CAL_LEN(CL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cal_req(cal_req),
    .SC(SC), .cal(cal), .sleep_n(sleep_n), .cs_n(cs_n), .drdy_n(drdy_n),
    .sclk(sclk), .sdata(sdata), .data(data), .data_ch(data_ch),
    .data_valid(data_valid), .abort_err(abort_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    ch;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   ch_model = 0;
  logic dv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected sample, on time.
  always @(negedge clock) begin
    if (data_valid) begin
      check("dv_single_cycle", dv_prev, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_data_valid", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data", data, mon_e.d);
        check("data_ch", data_ch, mon_e.ch);
        check("latency_cycle", cyc, mon_e.due);
        check("cs_n_after_done", cs_n, 1'b1);
      end
    end
    dv_prev = data_valid;
  end

  // ADC model: one conversion, optionally aborted, reset, or with enable dropped after a given sclk rise.
  task automatic do_conv(input logic [DW-1:0] w, input int abort_at, input int drop_at, input int rst_at);
    int   t;
    int   rises;
    logic prev;
    logic sc_stable;
    logic [1:0] sc0;
    int   cs_cyc;
    drdy_n = 1'b0;
    t = 0;
    while (cs_n !== 1'b0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("cs_fall_timeout", (t >= 300), 1'b0);
    if (t >= 300) begin
      drdy_n = 1'b1;
      return;
    end
    cs_cyc = cyc;
    sc0 = SC;
    check("sc_at_start", SC, ch_model[1:0]);
    if (abort_at == 0 && rst_at == 0) begin
      exp_q.push_back('{d: w, ch: ch_model[1:0], due: cs_cyc + LAT});
      ch_model = (ch_model + 1) % NCH;
    end
    sdata = w[DW-1];
    rises = 0;
    prev = 1'b0;
    sc_stable = 1'b1;
    t = 0;
    while (rises < DW && t < 1000) begin
      @(negedge clock);
      t++;
      if (SC !== sc0) sc_stable = 1'b0;
      if (sclk && !prev) begin
        rises++;
        if (rises < DW) sdata = w[DW-1-rises];
        if (rises == abort_at) begin
          drdy_n = 1'b1;
          @(negedge clock);
          check("abort_cs_n", cs_n, 1'b1);
          check("abort_sclk", sclk, 1'b0);
          check("abort_err", abort_err, 1'b1);
          check("abort_sc_kept", SC, ch_model[1:0]);
          repeat (6) @(negedge clock);
          return;
        end
        if (rises == rst_at) begin
          reset = 1'b1;
          @(negedge clock);
          check("rst_SC", SC, 2'd0);
          check("rst_cal", cal, 1'b0);
          check("rst_sleep_n", sleep_n, 1'b0);
          check("rst_cs_n", cs_n, 1'b1);
          check("rst_sclk", sclk, 1'b0);
          check("rst_data", data, '0);
          check("rst_data_ch", data_ch, 2'd0);
          check("rst_data_valid", data_valid, 1'b0);
          check("rst_abort_err", abort_err, 1'b0);
          reset = 1'b0;
          drdy_n = 1'b1;
          ch_model = 0;
          exp_q.delete();
          repeat (3) @(negedge clock);
          return;
        end
        if (rises == drop_at) enable = 1'b0;
      end
      prev = sclk;
    end
    drdy_n = 1'b1;
    check("rise_timeout", (rises < DW), 1'b0);
    check("sc_stable_in_shift", sc_stable, 1'b1);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("valid_timeout", (t >= 200), 1'b0);
    if (drop_at != 0) begin
      @(negedge clock);
      check("drop_en_sleep_n", sleep_n, 1'b0);
      check("drop_en_cs_n", cs_n, 1'b1);
      enable = 1'b1;
      repeat (2) @(negedge clock);
    end
  endtask

  // Calibration pulse issued in WAIT; drdy_n is pulled low during CAL and must be ignored.
  task automatic cal_test();
    int   t;
    int   n;
    logic cs_fell;
    drdy_n = 1'b1;
    repeat (3) @(negedge clock);
    cal_req = 1'b1;
    @(negedge clock);
    cal_req = 1'b0;
    t = 0;
    while (cal !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("cal_start_timeout", (t >= 20), 1'b0);
    drdy_n = 1'b0;
    n = 0;
    cs_fell = 1'b0;
    while (cal === 1'b1 && n < 50) begin
      n++;
      if (cs_n !== 1'b1) cs_fell = 1'b1;
      check("cal_sleep_n", sleep_n, 1'b1);
      @(negedge clock);
    end
    check("cal_len", n, CL);
    check("cal_no_cs_fall", cs_fell, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    int ab;
    reset   = 1'b1;
    enable  = 1'b0;
    cal_req = 1'b0;
    drdy_n  = 1'b1;
    sdata   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_sleep_n", sleep_n, 1'b0);
    check("reset_cs_n", cs_n, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_cal", cal, 1'b0);
    check("reset_dv", data_valid, 1'b0);
    check("reset_abort_err", abort_err, 1'b0);
    check("reset_SC", SC, 2'd0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clock);
    check("wait_sleep_n", sleep_n, 1'b1);

    // Known pattern, then four more back-to-back conversions: channels 0,1,2,0,1.
    do_conv(16'hA5C3, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_conv(DW'($urandom), 0, 0, 0);

    // Abort after the 5th sclk rise.
    do_conv(DW'($urandom), 5, 0, 0);

    // Calibration followed by the conversion drdy_n was requesting.
    cal_test();
    do_conv(DW'($urandom), 0, 0, 0);

    // Enable dropped mid-transfer.
    do_conv(DW'($urandom), 0, 9, 0);

    // Randomized mix of clean and aborted transfers with random gaps.
    for (int i = 0; i < 10; i++) begin
      g  = $urandom_range(0, 5);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
      repeat (g) @(negedge clock);
      do_conv(DW'($urandom), ab, 0, 0);
    end

    // Reset mid-transfer, then a clean conversion must come from channel 0.
    do_conv(DW'($urandom), 0, 0, 7);
    enable = 1'b1;
    do_conv(DW'($urandom), 0, 0, 0);

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
ADC_SERIAL_READER -- requirements
Module: adc_serial_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the sample width in bits (range 8..32).
REQ-002 SHALL have parameter NUM_CH, default 4, meaning the number of ADC channels scanned (range 1..4).
REQ-003 SHALL have parameter CLK_DIV, default 4, meaning the `clock` cycles per `sclk` half-period (range 1..255).
REQ-004 SHALL have parameter CAL_LEN, default 8, meaning the `clock` cycles `cal` is held high per calibration.
REQ-005 `clock`  in  1  is the single clock; all logic SHALL run on its rising edge.
REQ-006 `reset`  in  1  is synchronous and active-high.
REQ-007 `enable`  in  1  means conversions are allowed; low requests sleep.
REQ-008 `cal_req`  in  1  is a single-cycle calibration request.
REQ-009 `SC`  out  2  is the ADC channel select.
REQ-010 `cal`  out  1  is the ADC calibrate strobe.
REQ-011 `sleep_n`  out  1  is the ADC sleep control, active-low.
REQ-012 `cs_n`  out  1  is the ADC chip select, active-low.
REQ-013 `drdy_n`  in  1  is ADC data-ready, active-low.
REQ-014 `sclk`  out  1  is the serial clock, registered and generated from `clock`.
REQ-015 `sdata`  in  1  is serial data, MSB first.
REQ-016 `data`  out  DATA_W  is the last complete sample.
REQ-017 `data_ch`  out  2  is the channel of `data`.
REQ-018 `data_valid`  out  1  is a one-cycle pulse marking new `data`.
REQ-019 `abort_err`  out  1  is a sticky flag marking a truncated transfer.

Function
REQ-020 SHALL implement FSM states IDLE, CAL, WAIT, SHIFT, DONE.
REQ-021 `cal_req` SHALL set a pending flag.
- The flag SHALL be held until CAL is entered.
- A second request while pending SHALL be absorbed.
REQ-022 IDLE behaviour:
- Outputs: `sleep_n`=0, `cs_n`=1, `sclk`=0.
- `enable`=1 with cal pending -> CAL.
- `enable`=1 without cal pending -> WAIT.
REQ-023 CAL behaviour:
- `sleep_n`=1, `cal`=1 for exactly CAL_LEN cycles.
- Pending flag cleared on entry.
- Then -> WAIT.
- `drdy_n` SHALL be ignored in CAL.
REQ-024 WAIT behaviour:
- `sleep_n`=1.
- `drdy_n` sampled 0 -> SHIFT, with `cs_n`=0 in the first SHIFT cycle.
- Cal pending -> CAL. This SHALL take priority over `drdy_n`.
- `enable`=0 -> IDLE.
REQ-025 SHIFT timing:
- A divider counts 0..CLK_DIV-1; `sclk` SHALL toggle on wrap, starting from 0.
- `sdata` SHALL be shifted in MSB-first on each cycle where `sclk` goes 0->1.
- Total SHIFT duration SHALL be exactly 2*DATA_W*CLK_DIV cycles, ending with `sclk`=0.
REQ-026 SHIFT abort: if `drdy_n` is sampled 1 before the DATA_W-th rising edge:
- Go to WAIT.
- `cs_n`=1, `sclk`=0.
- Set `abort_err`=1.
- Discard the partial shift register.
- Do not pulse `data_valid`.
- Do not advance `SC`.
REQ-027 DONE (one cycle):
- `data` <= shift register, `data_ch` <= `SC`, `data_valid`=1.
- `cs_n`=1.
- `SC` <= `SC`+1, wrapping NUM_CH-1 -> 0.
- `enable`=1 -> WAIT; `enable`=0 -> IDLE.
REQ-028 `enable` deasserted during CAL or SHIFT SHALL take effect only after that state completes.
REQ-029 Latency SHALL be 2*DATA_W*CLK_DIV+1 cycles from the first SHIFT cycle to `data_valid`.
REQ-030 `data` and `data_ch` SHALL hold their values until the next DONE.
REQ-031 `SC` SHALL stay constant for a whole SHIFT; with NUM_CH=1, `SC` SHALL stay 0.
REQ-032 `abort_err` SHALL be cleared only by `reset`.

Reset
REQ-033 `reset` SHALL, from any state including mid-SHIFT, on the next edge:
- Go to IDLE.
- `SC`=0, `cal`=0, `sleep_n`=0, `cs_n`=1, `sclk`=0.
- `data`=0, `data_ch`=0, `data_valid`=0, `abort_err`=0.
- Clear the cal pending flag and the divider.

Verification
REQ-034 DATA_W=16, CLK_DIV=2; `enable`=1; `drdy_n` low; `sdata` drives 0xA5C3 MSB-first on `sclk` rises -> `data`=0xA5C3, `data_ch`=0, one-cycle `data_valid` 65 cycles after `cs_n` falls.
REQ-035 NUM_CH=3; five back-to-back conversions -> `data_ch` sequence 0,1,2,0,1.
REQ-036 `cal_req` pulse in WAIT, CAL_LEN=8 -> `cal` high exactly 8 cycles; `drdy_n` low during CAL causes no `cs_n` fall.
REQ-037 `drdy_n` rises after the 5th `sclk` rise -> `cs_n`=1 next cycle, `abort_err`=1, no `data_valid`, `SC` unchanged.
REQ-038 `reset` asserted mid-SHIFT -> next cycle shows all REQ-033 values; a subsequent conversion returns correct data from channel 0.
REQ-039 `enable` dropped mid-SHIFT -> transfer completes, `data_valid` pulses, then IDLE with `sleep_n`=0.
